ex_mdu: RTL
===========

# ex_mdu

Multiply/divide unit in the EX stage. Consumes the instruction class and forwarded operands latched by the ID/EX register, executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency, and holds the architectural HI/LO registers. Exports a busy/stall indication to the hazard unit, and serves MFHI/MFLO reads back into the EX result mux.

## Interface
- Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU
- DIV_CYCLES, 10, busy cycles for DIV/DIVU
- Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req  in  1  exception/interrupt flush; suppresses any op issued this cycle
- mdu_op  in  4  EX-stage op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9–15 treated as NONE
- rs_val  in  32  forwarded rs operand
- rt_val  in  32  forwarded rt operand
- busy  out  1  registered; high while an op is in flight
- mdu_stall  out  1  combinational: busy, or mdu_op is 1–4 this cycle
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- rdata  out  32  combinational: hi if MFHI, lo if MFLO, else 0

## Operation
- States: IDLE (cnt==0) and RUN (cnt!=0). busy = (cnt!=0).
- IDLE, op 1–4, req low: latch the result into pending_hi/pending_lo, load cnt with MULT_CYCLES or DIV_CYCLES, and go to RUN.
- Results: MULT = signed 64-bit product, MULTU = unsigned; {hi,lo} = product. DIV/DIVU: lo = quotient, hi = remainder; signed ops truncate toward zero, and the remainder takes the dividend's sign.
- Divide by zero: the op still runs DIV_CYCLES with busy high. HI/LO keep their previous values.
- RUN: cnt decrements each cycle. On the edge where cnt goes from 1 to 0, hi/lo take pending_hi/pending_lo.
- MTHI/MTLO in IDLE with req low write rs_val to hi or lo at the edge.
- Any op arriving in RUN is ignored, because the hazard unit guarantees none arrive.
- req high: the op presented that cycle is not started and not written. An op already in RUN is unaffected and completes normally, because it committed before the exception.
- MFHI/MFLO are pure reads of the current hi/lo and have no side effect.

## Timing
- Reset values: busy 0, cnt 0, hi 0, lo 0, pending_hi/pending_lo 0; mdu_stall and rdata follow their combinational rules.
- MULT issued in cycle T:
  - busy is high for cycles T+1 to T+5.
  - New hi/lo are visible in cycle T+6.
  - busy is low in cycle T+6.
- DIV issued in cycle T: busy is high for T+1 to T+10, and hi/lo update for cycle T+11.
- MTHI in cycle T: the new hi is visible in T+1.
- An op issued in the cycle right after busy falls is accepted. There is no dead cycle.
- reset mid-RUN clears cnt, hi and lo at that edge, and the pending result is discarded.

## Structure
- mdu_op encodings (MDU_NONE … MDU_MFLO) are defined as shared macros alongside the other instruction-class constants.
- MULT_CYCLES and DIV_CYCLES defaults are also defined as shared macros.
- One combinational sub-module, mdu_arith, computes the 64-bit {hi,lo} result from mdu_op, rs_val and rt_val.
- The counter, pending registers and HI/LO live in ex_mdu.

## Test plan
- MULT with rs=0xFFFFFFFE (−2) and rt=3:
  - busy is high exactly 5 cycles.
  - hi=0xFFFFFFFF and lo=0xFFFFFFFA from cycle T+6.
  - MULTU on the same operands gives hi=0x00000002, lo=0xFFFFFFFA.
- DIV with rs=−7 and rt=2:
  - busy is high exactly 10 cycles.
  - lo=0xFFFFFFFD and hi=0xFFFFFFFF.
  - DIVU 7/2 gives lo=3, hi=1.
- DIV with rt=0 after MTHI 0x1234 and MTLO 0x5678: busy is high 10 cycles, and hi/lo stay 0x1234/0x5678.
- MULT with req high in the same cycle:
  - busy stays 0 and hi/lo are unchanged.
  - mdu_stall is high that cycle.
  - req asserted during a running MULT does not stop it completing.
- MTHI 0xDEADBEEF followed next cycle by MFHI: rdata=0xDEADBEEF. MFLO after reset gives rdata=0.
- reset asserted in the 3rd busy cycle of a DIV: the next cycle shows busy=0, hi=0, lo=0, and no late write occurs.

Source files
------------

// File: rtl/ex_mdu_pkg.sv
// rtl/ex_mdu_pkg.sv - shared MDU op encodings, latency defaults and FSM state type
package ex_mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;
    localparam logic [3:0] MDU_MFHI  = 4'd7;
    localparam logic [3:0] MDU_MFLO  = 4'd8;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;
    localparam int MDU_CNT_W       = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op >= MDU_MULT) && (op <= MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational 64-bit {hi,lo} result for MULT/MULTU/DIV/DIVU
module mdu_arith
    import ex_mdu_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_rs,
    input  logic [31:0] i_rt,
    output logic [63:0] o_result,
    output logic        o_valid
);

    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod_u;
    logic               w_sdiv;
    logic        [31:0] w_a_mag;
    logic        [31:0] w_b_mag;
    logic        [31:0] w_q_mag;
    logic        [31:0] w_r_mag;
    logic        [31:0] w_q;
    logic        [31:0] w_r;

    assign w_prod_s = $signed({{32{i_rs[31]}}, i_rs}) * $signed({{32{i_rt[31]}}, i_rt});
    assign w_prod_u = {32'd0, i_rs} * {32'd0, i_rt};

    // Signed divide works on magnitudes; quotient sign is the XOR, remainder follows the dividend.
    assign w_sdiv  = (i_op == MDU_DIV);
    assign w_a_mag = (w_sdiv && i_rs[31]) ? (32'd0 - i_rs) : i_rs;
    assign w_b_mag = (w_sdiv && i_rt[31]) ? (32'd0 - i_rt) : i_rt;
    assign w_q_mag = (w_b_mag != 32'd0) ? (w_a_mag / w_b_mag) : 32'd0;
    assign w_r_mag = (w_b_mag != 32'd0) ? (w_a_mag % w_b_mag) : 32'd0;
    assign w_q     = (w_sdiv && (i_rs[31] ^ i_rt[31])) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_r     = (w_sdiv && i_rs[31]) ? (32'd0 - w_r_mag) : w_r_mag;

    always_comb begin
        o_result = '0;
        o_valid  = 1'b0;
        case (i_op)
            MDU_MULT: begin
                o_result = w_prod_s;
                o_valid  = 1'b1;
            end
            MDU_MULTU: begin
                o_result = w_prod_u;
                o_valid  = 1'b1;
            end
            MDU_DIV, MDU_DIVU: begin
                o_result = {w_r, w_q};
                o_valid  = (i_rt != 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ex_mdu.sv
// rtl/ex_mdu.sv - EX-stage multiply/divide unit with fixed latency and HI/LO registers
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        mdu_stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);

    logic [MDU_CNT_W-1:0] r_cnt;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;
    logic [31:0]          r_pend_hi;
    logic [31:0]          r_pend_lo;
    logic                 r_pend_ok;

    logic [MDU_CNT_W-1:0] w_cnt_nxt;
    logic [31:0]          w_hi_nxt;
    logic [31:0]          w_lo_nxt;
    logic [31:0]          w_pend_hi_nxt;
    logic [31:0]          w_pend_lo_nxt;
    logic                 w_pend_ok_nxt;
    logic [63:0]          w_result;
    logic                 w_result_ok;
    mdu_state_e           w_state;

    mdu_arith u_arith (
        .i_op     (mdu_op),
        .i_rs     (rs_val),
        .i_rt     (rt_val),
        .o_result (w_result),
        .o_valid  (w_result_ok)
    );

    assign w_state = (r_cnt != '0) ? S_RUN : S_IDLE;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_ok <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_pend_hi <= w_pend_hi_nxt;
            r_pend_lo <= w_pend_lo_nxt;
            r_pend_ok <= w_pend_ok_nxt;
        end
    end

    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_pend_hi_nxt = r_pend_hi;
        w_pend_lo_nxt = r_pend_lo;
        w_pend_ok_nxt = r_pend_ok;
        case (w_state)
            S_IDLE: begin
                if (!req) begin
                    case (mdu_op)
                        MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                            w_cnt_nxt     = (mdu_op == MDU_MULT || mdu_op == MDU_MULTU)
                                          ? MDU_CNT_W'(MULT_CYCLES) : MDU_CNT_W'(DIV_CYCLES);
                            w_pend_hi_nxt = w_result[63:32];
                            w_pend_lo_nxt = w_result[31:0];
                            w_pend_ok_nxt = w_result_ok;
                        end
                        MDU_MTHI: w_hi_nxt = rs_val;
                        MDU_MTLO: w_lo_nxt = rs_val;
                        MDU_NONE, MDU_MFHI, MDU_MFLO: ;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                w_cnt_nxt = r_cnt - 1'b1;
                // A divide-by-zero still runs the full latency but never commits.
                if (r_cnt == MDU_CNT_W'(1) && r_pend_ok) begin
                    w_hi_nxt = r_pend_hi;
                    w_lo_nxt = r_pend_lo;
                end
            end
            default: ;
        endcase
    end

    assign busy      = (r_cnt != '0);
    assign mdu_stall = busy || is_muldiv(mdu_op);
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign rdata     = (mdu_op == MDU_MFHI) ? r_hi :
                       (mdu_op == MDU_MFLO) ? r_lo : 32'd0;

endmodule
